// File: rtl/ps2_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_ctrl_pkg
// Brief  : Shared frame states, direction encoding and scan-code key map.
// Rev    : 1.0
// ============================================================================
package ps2_key_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    localparam logic [7:0] c_CODE_EXT   = 8'hE0;
    localparam logic [7:0] c_CODE_BREAK = 8'hF0;

    localparam logic [7:0] c_KEY_W     = 8'h1D;
    localparam logic [7:0] c_KEY_S     = 8'h1B;
    localparam logic [7:0] c_KEY_A     = 8'h1C;
    localparam logic [7:0] c_KEY_D     = 8'h23;
    localparam logic [7:0] c_KEY_UP    = 8'h75;
    localparam logic [7:0] c_KEY_DOWN  = 8'h72;
    localparam logic [7:0] c_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] c_KEY_RIGHT = 8'h74;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_map_t;

    // WASD live in the plain code space, arrows only behind an E0 prefix.
    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.dir = c_DIR_UP;
        if (!ext) begin
            case (code)
                c_KEY_W: m.dir = c_DIR_UP;
                c_KEY_S: m.dir = c_DIR_DOWN;
                c_KEY_A: m.dir = c_DIR_LEFT;
                c_KEY_D: m.dir = c_DIR_RIGHT;
                default: m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                c_KEY_UP:    m.dir = c_DIR_UP;
                c_KEY_DOWN:  m.dir = c_DIR_DOWN;
                c_KEY_LEFT:  m.dir = c_DIR_LEFT;
                c_KEY_RIGHT: m.dir = c_DIR_RIGHT;
                default:     m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_ctrl_line_filter.sv
`default_nettype none
// ============================================================================
// Module : ps2_line_filter
// Brief  : Two-flop synchronisers, PS2 clock glitch filter and falling-edge strobe.
// Rev    : 1.0
// ============================================================================
module ps2_line_filter
    import ps2_key_ctrl_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data,
    output logic o_strobe
);

    localparam int             CW          = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  c_CNT_LAST  = CW'(FILTER_LEN - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_strobe;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_cnt       <= '0;
            r_strobe    <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_strobe    <= 1'b0;
            // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
            if (r_clk_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_filt   <= r_clk_sync[1];
                r_cnt    <= '0;
                r_strobe <= r_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_data   = r_data_sync[1];
    assign o_strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_ctrl
// Brief  : PS/2 keyboard frame receiver with scan-code decode and move requests.
// Rev    : 1.0
// ============================================================================
module ps2_key_ctrl
    import ps2_key_ctrl_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       MOVE_ACK,
    output logic       CODE_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_BREAK,
    output logic       KEY_EXT,
    output logic       MOVE_VALID,
    output logic [1:0] MOVE_DIR,
    output logic [3:0] HELD,
    output logic       FRAME_ERR
);

    localparam int            TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          w_strobe;
    logic          w_data;
    frame_state_t  r_state;
    frame_state_t  w_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;
    logic          r_par;
    logic [TW-1:0] r_tocnt;
    logic          r_ext;
    logic          r_brk;
    logic          w_good;
    logic          w_bad;
    logic          w_timeout;
    logic          w_par_ok;
    key_map_t      w_byte_map;
    key_map_t      w_cv_map;
    logic          w_new_move;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .CLK        (CLK),
        .RST        (RST),
        .i_ps2_clk  (PS2_CLK),
        .i_ps2_data (PS2_DATA),
        .o_data     (w_data),
        .o_strobe   (w_strobe)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        w_par_ok  = ^{r_shift, r_par};
        w_timeout = (r_state != ST_IDLE) && !w_strobe && (r_tocnt == c_TO_LAST);
        if (w_strobe) begin
            case (r_state)
                ST_IDLE:   if (!w_data) w_next = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_next = ST_PARITY;
                ST_PARITY: w_next = ST_STOP;
                ST_STOP: begin
                    w_next = ST_IDLE;
                    if (w_data && w_par_ok) w_good = 1'b1;
                    else                    w_bad  = 1'b1;
                end
                default:   w_next = ST_IDLE;
            endcase
        end
        if (w_timeout) w_next = ST_IDLE;
        w_byte_map = map_key(r_shift, r_ext);
        w_cv_map   = map_key(KEY_CODE, KEY_EXT);
        // Moves are derived from the published code, so they land one cycle after CODE_VALID.
        w_new_move = CODE_VALID && w_cv_map.hit && !KEY_BREAK;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par      <= 1'b0;
            r_tocnt    <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            CODE_VALID <= 1'b0;
            KEY_CODE   <= '0;
            KEY_BREAK  <= 1'b0;
            KEY_EXT    <= 1'b0;
            MOVE_VALID <= 1'b0;
            MOVE_DIR   <= '0;
            HELD       <= '0;
            FRAME_ERR  <= 1'b0;
        end else begin
            CODE_VALID <= 1'b0;
            FRAME_ERR  <= w_bad | w_timeout;

            if (r_state == ST_IDLE || w_strobe) r_tocnt <= '0;
            else                                r_tocnt <= r_tocnt + 1'b1;

            if (w_strobe) begin
                case (r_state)
                    ST_IDLE:   r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    ST_PARITY: r_par <= w_data;
                    default:   ;
                endcase
            end

            if (w_bad || w_timeout) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_good) begin
                if (r_shift == c_CODE_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == c_CODE_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    CODE_VALID <= 1'b1;
                    KEY_CODE   <= r_shift;
                    KEY_BREAK  <= r_brk;
                    KEY_EXT    <= r_ext;
                    r_ext      <= 1'b0;
                    r_brk      <= 1'b0;
                    if (w_byte_map.hit) HELD[w_byte_map.dir] <= ~r_brk;
                end
            end

            // A fresh move outranks an ack landing in the same cycle.
            if (w_new_move) begin
                MOVE_VALID <= 1'b1;
                MOVE_DIR   <= w_cv_map.dir;
            end else if (MOVE_VALID && MOVE_ACK) begin
                MOVE_VALID <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
